// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Owns the architectural PC, fetches the instruction at that PC through a
//   req/ready handshake, holds it for decode until the datapath acks it, then
//   loads the next PC supplied by the external next-PC logic. Misaligned next
//   PCs and fetches that wait too long for memory latch a sticky fault that
//   only reset clears.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   TIMEOUT   non-stalled cycles a request may wait for imem_ready (1..255)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   pc_out                     current PC, feeds next-PC logic
//   npc_in                     next PC, sampled only on an accepted ack
//   instr_ack, stall           retire current instruction / freeze unit
//   imem_req, imem_addr        fetch request and address (== pc_out)
//   imem_ready, imem_rdata     memory response and instruction word
//   instr_out, instr_valid     registered instruction for decode
//   fault, fault_cause         sticky fault, 01 misaligned / 10 timeout
//   fault_pc                   offending address
//   fetch_count                instructions captured since reset (wraps)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] npc_in,
    input  logic        instr_ack,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    // Last wait-count value before the timeout fires: TIMEOUT waiting
    // cycles in total, counted from 0.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  wait_q, wait_d;

    // Request is combinational so memory sees it in the same cycle the FSM
    // enters REQ; reset masks it even though state only clears at the edge.
    assign imem_req = (state_q == S_REQ) & ~stall & ~reset;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        wait_d     = wait_q;

        case (state_q)
            S_REQ: begin
                if (imem_req && imem_ready) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                    wait_d  = '0;
                    state_d = S_HOLD;
                end else if (!stall) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d    = S_FAULT;
                        fault_d    = 1'b1;
                        cause_d    = CAUSE_TIMEOUT;
                        fault_pc_d = pc_q;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end

            S_HOLD: begin
                if (instr_ack && !stall) begin
                    valid_d = 1'b0;
                    if (npc_in[1:0] == 2'b00) begin
                        pc_d    = npc_in;
                        state_d = S_REQ;
                    end else begin
                        state_d    = S_FAULT;
                        fault_d    = 1'b1;
                        cause_d    = CAUSE_MISALIGN;
                        fault_pc_d = npc_in;
                    end
                end
            end

            S_FAULT: begin
                // Terminal: everything holds until reset.
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            cause_q    <= '0;
            fault_pc_q <= '0;
            count_q    <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
        end
    end

    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] npc_in;
    logic        instr_ack;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_out      (pc_out),
        .npc_in      (npc_in),
        .instr_ack   (instr_ack),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_pc    (fault_pc),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        ack;
        logic        rdy;
        logic [31:0] rdata;
        logic [31:0] npc;
        logic        x_req;    // imem_req before the edge
        logic [31:0] x_pc;     // values after the edge
        logic        x_valid;
        logic [31:0] x_instr;
        logic        x_fault;
        logic [1:0]  x_cause;
        logic [31:0] x_fpc;
        logic [31:0] x_count;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step%0d got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic ack,
                         input logic rdy, input logic [31:0] rdata,
                         input logic [31:0] npc);
        @(negedge clk);
        reset      = rst;
        stall      = stl;
        instr_ack  = ack;
        imem_ready = rdy;
        imem_rdata = rdata;
        npc_in     = npc;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        instr_ack  = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        npc_in     = '0;

        //          rst  stl  ack  rdy  rdata          npc            req  pc             vld  instr          flt  cause  fpc            count
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,         32'h0,         1'b0,32'h0000_3000,1'b0,32'h0,         1'b0,2'b00,32'h0,         32'd0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,32'h2408_0005,32'h0,         1'b1,32'h0000_3000,1'b1,32'h2408_0005,1'b0,2'b00,32'h0,         32'd1};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,32'h1111_1111,32'h0000_3004,1'b0,32'h0000_3004,1'b0,32'h2408_0005,1'b0,2'b00,32'h0,         32'd1};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,32'h2222_2222,32'h0,         1'b1,32'h0000_3004,1'b1,32'h2222_2222,1'b0,2'b00,32'h0,         32'd2};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,32'h0,         32'h0000_3008,1'b0,32'h0000_3008,1'b0,32'h2222_2222,1'b0,2'b00,32'h0,         32'd2};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,32'h3333_3333,32'h0000_300C,1'b1,32'h0000_3008,1'b1,32'h3333_3333,1'b0,2'b00,32'h0,         32'd3};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,         32'h0000_300C,1'b0,32'h0000_3008,1'b1,32'h3333_3333,1'b0,2'b00,32'h0,         32'd3};
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,         32'h0000_300C,1'b0,32'h0000_3008,1'b1,32'h3333_3333,1'b0,2'b00,32'h0,         32'd3};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,         32'h0000_300C,1'b0,32'h0000_300C,1'b0,32'h3333_3333,1'b0,2'b00,32'h0,         32'd3};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,32'h4444_4444,32'h0,         1'b0,32'h0000_300C,1'b0,32'h3333_3333,1'b0,2'b00,32'h0,         32'd3};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,32'h4444_4444,32'h0,         1'b1,32'h0000_300C,1'b0,32'h3333_3333,1'b0,2'b00,32'h0,         32'd3};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b1,32'h4444_4444,32'h0,         1'b1,32'h0000_300C,1'b1,32'h4444_4444,1'b0,2'b00,32'h0,         32'd4};
        vecs[12] = '{1'b0,1'b0,1'b1,1'b1,32'h9999_9999,32'h0000_3010,1'b0,32'h0000_3010,1'b0,32'h4444_4444,1'b0,2'b00,32'h0,         32'd4};
        // reset beats a simultaneous handshake and ack
        vecs[13] = '{1'b1,1'b0,1'b1,1'b1,32'h5555_5555,32'h0000_3014,1'b0,32'h0000_3000,1'b0,32'h0,         1'b0,2'b00,32'h0,         32'd0};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b1,32'h2408_0005,32'h0,         1'b1,32'h0000_3000,1'b1,32'h2408_0005,1'b0,2'b00,32'h0,         32'd1};
        vecs[15] = '{1'b0,1'b0,1'b1,1'b0,32'h0,         32'h0000_3006,1'b0,32'h0000_3000,1'b0,32'h2408_0005,1'b1,2'b01,32'h0000_3006,32'd1};
        vecs[16] = '{1'b0,1'b0,1'b1,1'b1,32'h7777_7777,32'h0000_3004,1'b0,32'h0000_3000,1'b0,32'h2408_0005,1'b1,2'b01,32'h0000_3006,32'd1};
        vecs[17] = '{1'b1,1'b0,1'b0,1'b0,32'h0,         32'h0,         1'b0,32'h0000_3000,1'b0,32'h0,         1'b0,2'b00,32'h0,         32'd0};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b1,32'hAAAA_0001,32'h0,         1'b1,32'h0000_3000,1'b1,32'hAAAA_0001,1'b0,2'b00,32'h0,         32'd1};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].ack, vecs[i].rdy,
                  vecs[i].rdata, vecs[i].npc);
            chk("imem_req", i, 32'(imem_req), 32'(vecs[i].x_req));
            edge_wait();
            chk("pc_out", i, pc_out, vecs[i].x_pc);
            chk("imem_addr", i, imem_addr, vecs[i].x_pc);
            chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].x_valid));
            chk("instr_out", i, instr_out, vecs[i].x_instr);
            chk("fault", i, 32'(fault), 32'(vecs[i].x_fault));
            chk("fault_cause", i, 32'(fault_cause), 32'(vecs[i].x_cause));
            chk("fault_pc", i, fault_pc, vecs[i].x_fpc);
            chk("fetch_count", i, fetch_count, vecs[i].x_count);
        end

        // Fetch timeout: 16 non-stalled waiting cycles, with stalls mixed in
        // that must not count toward the limit.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        edge_wait();
        for (int n = 1; n <= 15; n++) begin
            if (n == 6) begin
                for (int s = 0; s < 3; s++) begin
                    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
                    edge_wait();
                    chk("to_stall_fault", 100 + s, 32'(fault), 32'd0);
                end
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            chk("to_req", 200 + n, 32'(imem_req), 32'd1);
            edge_wait();
            chk("to_wait_fault", 200 + n, 32'(fault), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        edge_wait();
        chk("to_fault", 300, 32'(fault), 32'd1);
        chk("to_cause", 300, 32'(fault_cause), 32'd2);
        chk("to_fpc", 300, fault_pc, 32'h0000_3000);
        chk("to_valid", 300, 32'(instr_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h0000_3004);
        chk("to_req_after", 301, 32'(imem_req), 32'd0);
        edge_wait();
        chk("to_count_frozen", 301, fetch_count, 32'd0);
        chk("to_pc_frozen", 301, pc_out, 32'h0000_3000);
        chk("to_fault_sticky", 301, 32'(fault), 32'd1);

        // Stall held in HOLD with ack for 4 cycles, then release.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        edge_wait();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0000, 32'h0);
        edge_wait();
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_3004);
            edge_wait();
            chk("st_pc", 400 + s, pc_out, 32'h0000_3000);
            chk("st_valid", 400 + s, 32'(instr_valid), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3004);
        edge_wait();
        chk("st_release_pc", 404, pc_out, 32'h0000_3004);
        chk("st_release_valid", 404, 32'(instr_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("st_next_req", 405, 32'(imem_req), 32'd1);
        edge_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
